// File: rtl/mem_wb_pipe_pkg.sv
// Shared types and constants for the MEM/WB stage register.
// Payload field order (MSB..LSB): {csr_waddr, csr_wdata, csr_we, reg_waddr, reg_wdata, reg_we}.
package mem_wb_pipe_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_RADDR_W    = 5;
    localparam int DEF_CSR_ADDR_W = 12;

    localparam logic ZERO          = 1'b0;
    localparam int   ZERO_REG      = 0;
    localparam int   CSR_ZERO_ADDR = 0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    // Buffer occupancy: output entry only, or output plus skid entry.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_e;

    // Width of one packed payload entry.
    function automatic int payload_width(input int data_w, input int raddr_w, input int csr_addr_w);
        return csr_addr_w + data_w + 1 + raddr_w + data_w + 1;
    endfunction

    // A GPR write to x0 is dropped when the entry is captured.
    function automatic logic sanitise_reg_we(input logic we, input logic addr_is_zero);
        return (we & ~addr_is_zero) ? WRITE_ENABLE : WRITE_DISABLE;
    endfunction

endpackage

// File: rtl/mem_wb_pipe_if.sv
// Handshake and write-port bundle between MEM, this stage and the WB write ports.
interface mem_wb_pipe_if
    import mem_wb_pipe_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RADDR_W    = DEF_RADDR_W,
    parameter int CSR_ADDR_W = DEF_CSR_ADDR_W
) ();

    logic                  valid_in;
    logic                  ready_out;
    logic [DATA_W-1:0]     reg_wdata_in;
    logic [RADDR_W-1:0]    reg_waddr_in;
    logic                  reg_we_in;
    logic                  csr_we_in;
    logic [DATA_W-1:0]     csr_wdata_in;
    logic [CSR_ADDR_W-1:0] csr_waddr_in;
    logic                  interrupt_flush_in;
    logic                  wb_stall_in;
    logic                  valid_out;
    logic [DATA_W-1:0]     reg_wdata_out;
    logic [RADDR_W-1:0]    reg_waddr_out;
    logic                  reg_we_out;
    logic                  csr_we_out;
    logic [DATA_W-1:0]     csr_wdata_out;
    logic [CSR_ADDR_W-1:0] csr_waddr_out;
    logic                  instret_incr_out;

    // View of the stage itself.
    modport slave (
        input  valid_in, reg_wdata_in, reg_waddr_in, reg_we_in,
               csr_we_in, csr_wdata_in, csr_waddr_in,
               interrupt_flush_in, wb_stall_in,
        output ready_out, valid_out, reg_wdata_out, reg_waddr_out, reg_we_out,
               csr_we_out, csr_wdata_out, csr_waddr_out, instret_incr_out
    );

    // View of the surrounding pipeline driving the stage.
    modport master (
        output valid_in, reg_wdata_in, reg_waddr_in, reg_we_in,
               csr_we_in, csr_wdata_in, csr_waddr_in,
               interrupt_flush_in, wb_stall_in,
        input  ready_out, valid_out, reg_wdata_out, reg_waddr_out, reg_we_out,
               csr_we_out, csr_wdata_out, csr_waddr_out, instret_incr_out
    );

endinterface

// File: rtl/mem_wb_pipe_chk.sv
// Structural invariants of the MEM/WB buffer.
module mem_wb_pipe_chk (
    input logic       clk_in,
    input logic       reset_n_in,
    input logic [1:0] state_in,
    input logic       valid_out_in,
    input logic       instret_in
);

    // Occupancy never exceeds two entries.
    a_occ_max: assert property (@(posedge clk_in) disable iff (!reset_n_in) state_in != 2'd3);

    // A retire pulse always belongs to a presented instruction.
    a_retire_valid: assert property (@(posedge clk_in) disable iff (!reset_n_in) instret_in |-> valid_out_in);

endmodule

// File: rtl/mem_wb_pipe_slot.sv
// One packed payload register with load, synchronous clear and async reset.
module mem_wb_slot #(
    parameter int WIDTH = 1
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic             load_in,
    input  logic             clr_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next value: clear beats load, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (clr_in) begin
            data_d = '0;
        end else if (load_in) begin
            data_d = data_in;
        end else begin
            data_d = data_q;
        end
    end

    // Payload storage, zeroed by reset.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB stage register with valid/ready handshake, optional skid entry,
// interrupt flush and a retire pulse for the instret counter.
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RADDR_W    = DEF_RADDR_W,
    parameter int CSR_ADDR_W = DEF_CSR_ADDR_W,
    parameter bit SKID_EN    = 1'b1
) (
    input logic          clk_in,
    input logic          reset_n_in,
    mem_wb_pipe_if.slave bus
);

    localparam int PAY_W         = payload_width(DATA_W, RADDR_W, CSR_ADDR_W);
    localparam int REG_WE_LSB    = 0;
    localparam int REG_WDATA_LSB = REG_WE_LSB + 1;
    localparam int REG_WADDR_LSB = REG_WDATA_LSB + DATA_W;
    localparam int CSR_WE_LSB    = REG_WADDR_LSB + RADDR_W;
    localparam int CSR_WDATA_LSB = CSR_WE_LSB + 1;
    localparam int CSR_WADDR_LSB = CSR_WDATA_LSB + DATA_W;

    occ_state_e       state_q, state_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             ready_s, accept_s, consume_s, reg_we_s;
    logic             out_load_s, out_clr_s, out_sel_skid_s;
    logic             skid_load_s, skid_clr_s;
    logic [PAY_W-1:0] pay_in_s, out_din_s, out_pay_s, skid_pay_s;

    assign reg_we_s = sanitise_reg_we(bus.reg_we_in, (bus.reg_waddr_in == RADDR_W'(ZERO_REG)));
    assign pay_in_s = {bus.csr_waddr_in, bus.csr_wdata_in, bus.csr_we_in,
                       bus.reg_waddr_in, bus.reg_wdata_in, reg_we_s};

    // Handshake terms; a flush cycle never accepts new work.
    always_comb begin
        ready_s = 1'b1;
        if (SKID_EN) begin
            ready_s = ready_q;
        end else begin
            ready_s = ~valid_q | ~bus.wb_stall_in;
        end
        accept_s  = bus.valid_in & ready_s & ~bus.interrupt_flush_in;
        consume_s = valid_q & ~bus.wb_stall_in;
    end

    // Occupancy transitions and slot control.
    always_comb begin
        state_d        = state_q;
        out_load_s     = 1'b0;
        out_clr_s      = 1'b0;
        out_sel_skid_s = 1'b0;
        skid_load_s    = 1'b0;
        skid_clr_s     = 1'b0;
        if (bus.interrupt_flush_in) begin
            state_d    = ST_EMPTY;
            out_clr_s  = 1'b1;
            skid_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d    = ST_ONE;
                        out_load_s = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && consume_s) begin
                        state_d    = ST_ONE;
                        out_load_s = 1'b1;
                    end else if (accept_s && (SKID_EN == 1'b1)) begin
                        state_d     = ST_TWO;
                        skid_load_s = 1'b1;
                    end else if (consume_s) begin
                        state_d   = ST_EMPTY;
                        out_clr_s = 1'b1;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (consume_s) begin
                        state_d        = ST_ONE;
                        out_load_s     = 1'b1;
                        out_sel_skid_s = 1'b1;
                        skid_clr_s     = 1'b1;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    out_clr_s  = 1'b1;
                    skid_clr_s = 1'b1;
                end
            endcase
        end
        valid_d = (state_d != ST_EMPTY);
        ready_d = (state_d != ST_TWO);
    end

    // Occupancy state plus registered valid/ready decodes.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    // Output slot loads either fresh MEM data or the skid entry.
    always_comb begin
        out_din_s = pay_in_s;
        if (out_sel_skid_s) begin
            out_din_s = skid_pay_s;
        end else begin
            out_din_s = pay_in_s;
        end
    end

    mem_wb_slot #(.WIDTH(PAY_W)) u_out_slot (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .load_in    (out_load_s),
        .clr_in     (out_clr_s),
        .data_in    (out_din_s),
        .data_out   (out_pay_s)
    );

    if (SKID_EN) begin : g_skid
        mem_wb_slot #(.WIDTH(PAY_W)) u_skid_slot (
            .clk_in     (clk_in),
            .reset_n_in (reset_n_in),
            .load_in    (skid_load_s),
            .clr_in     (skid_clr_s),
            .data_in    (pay_in_s),
            .data_out   (skid_pay_s)
        );
    end else begin : g_no_skid
        logic skid_unused_s;
        assign skid_pay_s    = '0;
        assign skid_unused_s = skid_load_s ^ skid_clr_s ^ ready_q;
    end

    assign bus.valid_out        = valid_q;
    assign bus.ready_out        = ready_s;
    assign bus.instret_incr_out = consume_s;
    assign bus.reg_we_out       = out_pay_s[REG_WE_LSB] & valid_q;
    assign bus.reg_wdata_out    = out_pay_s[REG_WDATA_LSB +: DATA_W];
    assign bus.reg_waddr_out    = out_pay_s[REG_WADDR_LSB +: RADDR_W];
    assign bus.csr_we_out       = out_pay_s[CSR_WE_LSB] & valid_q;
    assign bus.csr_wdata_out    = out_pay_s[CSR_WDATA_LSB +: DATA_W];
    assign bus.csr_waddr_out    = out_pay_s[CSR_WADDR_LSB +: CSR_ADDR_W];

    mem_wb_pipe_chk u_chk (
        .clk_in       (clk_in),
        .reset_n_in   (reset_n_in),
        .state_in     (state_q),
        .valid_out_in (valid_q),
        .instret_in   (consume_s)
    );

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: a skid build and a single-entry build share stimulus;
// each is compared against a queue-level model, and the skid build also against
// a hand-derived vector table.
module tb_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v, stall, flush, we, cwe;
    logic [4:0]  wa;
    logic [31:0] wd, cwd;
    logic [11:0] cwa;

    always #5 clk = ~clk;

    mem_wb_pipe_if #(.DATA_W(32), .RADDR_W(5), .CSR_ADDR_W(12)) bus1 ();
    mem_wb_pipe_if #(.DATA_W(32), .RADDR_W(5), .CSR_ADDR_W(12)) bus0 ();

    assign bus1.valid_in = v;           assign bus0.valid_in = v;
    assign bus1.wb_stall_in = stall;    assign bus0.wb_stall_in = stall;
    assign bus1.interrupt_flush_in = flush; assign bus0.interrupt_flush_in = flush;
    assign bus1.reg_we_in = we;         assign bus0.reg_we_in = we;
    assign bus1.reg_waddr_in = wa;      assign bus0.reg_waddr_in = wa;
    assign bus1.reg_wdata_in = wd;      assign bus0.reg_wdata_in = wd;
    assign bus1.csr_we_in = cwe;        assign bus0.csr_we_in = cwe;
    assign bus1.csr_waddr_in = cwa;     assign bus0.csr_waddr_in = cwa;
    assign bus1.csr_wdata_in = cwd;     assign bus0.csr_wdata_in = cwd;

    mem_wb_pipe #(.DATA_W(32), .RADDR_W(5), .CSR_ADDR_W(12), .SKID_EN(1'b1)) dut1 (
        .clk_in(clk), .reset_n_in(rst_n), .bus(bus1));
    mem_wb_pipe #(.DATA_W(32), .RADDR_W(5), .CSR_ADDR_W(12), .SKID_EN(1'b0)) dut0 (
        .clk_in(clk), .reset_n_in(rst_n), .bus(bus0));

    typedef struct {
        logic rwe; logic [4:0] rwa; logic [31:0] rwd;
        logic cwe; logic [11:0] cwa; logic [31:0] cwd;
    } ent_t;

    typedef struct {
        logic v, st, fl; logic [4:0] wa; logic [31:0] wd;
        logic ev, er, ei, ewe; logic [4:0] ewa; logic [31:0] ewd;
    } vec_t;

    ent_t mq[2][2];
    int   mcnt[2];
    int   total = 0;
    int   bad = 0;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Model: instance 1 has two places, instance 0 has one.
    function automatic logic m_ready(input int k);
        if (k == 1) return mcnt[k] < 2;
        return (mcnt[k] == 0) || !stall;
    endfunction

    task automatic check_dut(input int k, input logic ov, ordy, oi, owe,
                             input logic [4:0] owa, input logic [31:0] owd,
                             input logic ocwe, input logic [11:0] ocwa, input logic [31:0] ocwd);
        logic ev;
        ent_t e;
        ev = mcnt[k] > 0;
        e  = mq[k][0];
        chk($sformatf("d%0d valid_out", k), 64'(ov), 64'(ev));
        chk($sformatf("d%0d ready_out", k), 64'(ordy), 64'(m_ready(k)));
        chk($sformatf("d%0d instret", k), 64'(oi), 64'(ev && !stall));
        chk($sformatf("d%0d reg_we_out", k), 64'(owe), 64'(ev && e.rwe));
        chk($sformatf("d%0d csr_we_out", k), 64'(ocwe), 64'(ev && e.cwe));
        if (ev) begin
            chk($sformatf("d%0d reg_waddr_out", k), 64'(owa), 64'(e.rwa));
            chk($sformatf("d%0d reg_wdata_out", k), 64'(owd), 64'(e.rwd));
            chk($sformatf("d%0d csr_waddr_out", k), 64'(ocwa), 64'(e.cwa));
            chk($sformatf("d%0d csr_wdata_out", k), 64'(ocwd), 64'(e.cwd));
        end
    endtask

    task automatic m_update();
        for (int k = 0; k < 2; k++) begin
            logic rdy, cons, acc;
            ent_t n;
            if (!rst_n) begin
                mcnt[k] = 0;
            end else begin
                rdy  = m_ready(k);
                cons = (mcnt[k] > 0) && !stall;
                acc  = v && rdy && !flush;
                if (cons) begin
                    mq[k][0] = mq[k][1];
                    mcnt[k]--;
                end
                if (flush) begin
                    mcnt[k] = 0;
                end else if (acc) begin
                    n.rwe = we && (wa != 5'd0);
                    n.rwa = wa; n.rwd = wd; n.cwe = cwe; n.cwa = cwa; n.cwd = cwd;
                    mq[k][mcnt[k]] = n;
                    mcnt[k]++;
                end
            end
        end
    endtask

    task automatic drive(input logic iv, ist, ifl, input logic [4:0] iwa, input logic [31:0] iwd);
        v = iv; stall = ist; flush = ifl; we = 1'b1; wa = iwa; wd = iwd;
        cwe = 1'b1; cwa = 12'h300 | 12'(iwa); cwd = ~iwd;
    endtask

    task automatic settle();
        #1;
        check_dut(1, bus1.valid_out, bus1.ready_out, bus1.instret_incr_out, bus1.reg_we_out,
                  bus1.reg_waddr_out, bus1.reg_wdata_out, bus1.csr_we_out, bus1.csr_waddr_out, bus1.csr_wdata_out);
        check_dut(0, bus0.valid_out, bus0.ready_out, bus0.instret_incr_out, bus0.reg_we_out,
                  bus0.reg_waddr_out, bus0.reg_wdata_out, bus0.csr_we_out, bus0.csr_waddr_out, bus0.csr_wdata_out);
    endtask

    task automatic adv();
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic iv, ist, ifl, input logic [4:0] iwa, input logic [31:0] iwd,
                                input logic ev, er, ei, ewe, input logic [4:0] ewa, input logic [31:0] ewd);
        vec_t t;
        t.v = iv; t.st = ist; t.fl = ifl; t.wa = iwa; t.wd = iwd;
        t.ev = ev; t.er = er; t.ei = ei; t.ewe = ewe; t.ewa = ewa; t.ewd = ewd;
        return t;
    endfunction

    initial begin
        int retires;
        // Stream of eight back-to-back instructions, then drain.
        for (int n = 1; n <= 8; n++) begin
            tbl.push_back(mk(1'b1, 1'b0, 1'b0, 5'(n), 32'h100 + 32'(n),
                             n > 1, 1'b1, n > 1, n > 1, 5'(n - 1), 32'h100 + 32'(n - 1)));
        end
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 32'h108));
        // Stall and skid: A, B, C with upstream holding C.
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 5'd1, 32'h101, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 5'd2, 32'h102, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 32'h101));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 5'd3, 32'h103, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h101));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 5'd3, 32'h103, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h101));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 5'd3, 32'h103, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h101));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 5'd3, 32'h103, 1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 32'h102));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0, 32'd0,   1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 32'h103));
        // Write to x0 is kept as an instruction but its GPR enable is dropped.
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'hDEADBEEF));
        // Flush with both entries stalled: nothing retires, D refused.
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 5'd1, 32'h101, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 5'd2, 32'h102, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 32'h101));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 5'd4, 32'h104, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h101));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0, 32'd0,   1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0));
        // Flush with an unstalled output entry: it still commits, F refused.
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 5'd5, 32'h105, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 5'd6, 32'h106, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 32'h105));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0, 32'd0,   1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0));

        // Reset asserted mid-cycle with random inputs.
        mcnt[0] = 0; mcnt[1] = 0;
        rst_n = 1'b1;
        drive(1'($urandom), 1'($urandom), 1'b0, 5'($urandom), $urandom);
        #2 rst_n = 1'b0;
        #1;
        chk("reset valid_out", 64'(bus1.valid_out), 64'd0);
        chk("reset ready_out", 64'(bus1.ready_out), 64'd1);
        chk("reset instret", 64'(bus1.instret_incr_out), 64'd0);
        chk("reset reg_we_out", 64'(bus1.reg_we_out), 64'd0);
        chk("reset csr_we_out", 64'(bus1.csr_we_out), 64'd0);
        chk("reset reg_wdata_out", 64'(bus1.reg_wdata_out), 64'd0);
        chk("reset reg_waddr_out", 64'(bus1.reg_waddr_out), 64'd0);
        chk("reset csr_waddr_out", 64'(bus1.csr_waddr_out), 64'd0);
        chk("reset csr_wdata_out", 64'(bus1.csr_wdata_out), 64'd0);
        chk("reset d0 valid_out", 64'(bus0.valid_out), 64'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
            settle();
            chk("post-reset instret", 64'(bus1.instret_incr_out), 64'd0);
            adv();
        end

        // Directed table against the skid build.
        retires = 0;
        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].v, tbl[r].st, tbl[r].fl, tbl[r].wa, tbl[r].wd);
            settle();
            chk($sformatf("tbl[%0d] valid_out", r), 64'(bus1.valid_out), 64'(tbl[r].ev));
            chk($sformatf("tbl[%0d] ready_out", r), 64'(bus1.ready_out), 64'(tbl[r].er));
            chk($sformatf("tbl[%0d] instret", r), 64'(bus1.instret_incr_out), 64'(tbl[r].ei));
            chk($sformatf("tbl[%0d] reg_we_out", r), 64'(bus1.reg_we_out), 64'(tbl[r].ewe));
            chk($sformatf("tbl[%0d] csr_we_out", r), 64'(bus1.csr_we_out), 64'(tbl[r].ev));
            if (tbl[r].ev) begin
                chk($sformatf("tbl[%0d] reg_waddr_out", r), 64'(bus1.reg_waddr_out), 64'(tbl[r].ewa));
                chk($sformatf("tbl[%0d] reg_wdata_out", r), 64'(bus1.reg_wdata_out), 64'(tbl[r].ewd));
            end
            if (r < 9) retires += int'(bus1.instret_incr_out);
            adv();
        end
        chk("stream retire count", 64'(retires), 64'd8);

        // Single-entry build drops ready in the same cycle as the stall.
        drive(1'b1, 1'b0, 1'b0, 5'd1, 32'h201);
        settle();
        adv();
        drive(1'b1, 1'b1, 1'b0, 5'd2, 32'h202);
        settle();
        chk("d0 ready falls with stall", 64'(bus0.ready_out), 64'd0);
        chk("d1 ready stays high", 64'(bus1.ready_out), 64'd1);
        adv();

        // Reset while stalled with entries held: they vanish without a pulse.
        drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h203);
        settle();
        #2 rst_n = 1'b0;
        #1;
        mcnt[0] = 0; mcnt[1] = 0;
        chk("mid-stall reset valid_out", 64'(bus1.valid_out), 64'd0);
        chk("mid-stall reset instret", 64'(bus1.instret_incr_out), 64'd0);
        chk("mid-stall reset ready_out", 64'(bus1.ready_out), 64'd1);
        chk("mid-stall reset reg_wdata_out", 64'(bus1.reg_wdata_out), 64'd0);
        adv();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
            settle();
            adv();
        end

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
            we  = 1'($urandom);
            cwe = 1'($urandom);
            cwa = 12'($urandom);
            cwd = $urandom;
            settle();
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM/WB stage register: the successor to the fixed single-stage register.
- Adds a valid/ready handshake toward MEM, a stall input from WB, and an optional skid entry so `ready_out` is registered.
- Retains interrupt flush. Generates a real `instret_incr_out` retire pulse.
- Sits between the mem stage and the regfile/csrfile write ports.

Parameters:
- DATA_W, 32, width of GPR and CSR write data.
- RADDR_W, 5, GPR address width.
- CSR_ADDR_W, 12, CSR address width.
- SKID_EN, 1, 1 = two-entry (output + skid) buffer with registered `ready_out`; 0 = single entry.

Ports:
- clk_in  in  1  clock
- reset_n_in  in  1  asynchronous active-low reset
- valid_in  in  1  MEM presents an instruction
- ready_out  out  1  stage can accept this cycle
- reg_wdata_in  in  DATA_W  GPR write data
- reg_waddr_in  in  RADDR_W  GPR write address
- reg_we_in  in  1  GPR write enable
- csr_we_in  in  1  CSR write enable
- csr_wdata_in  in  DATA_W  CSR write data
- csr_waddr_in  in  CSR_ADDR_W  CSR write address
- interrupt_flush_in  in  1  discard all held entries
- wb_stall_in  in  1  WB cannot consume this cycle
- valid_out  out  1  output entry holds an instruction
- reg_wdata_out  out  DATA_W  to regfile
- reg_waddr_out  out  RADDR_W  to regfile
- reg_we_out  out  1  to regfile
- csr_we_out  out  1  to csrfile
- csr_wdata_out  out  DATA_W  to csrfile
- csr_waddr_out  out  CSR_ADDR_W  to csrfile
- instret_incr_out  out  1  one-cycle retire pulse to csrfile

Behaviour:
- Reset (`reset_n_in`=0, async assert, sync deassert via the clock):
  - all payload regs zero; addresses = ZERO_REG / CSR_ZERO_ADDR.
  - both entries invalid; `valid_out`=0, `ready_out`=1.
  - all enables and `instret_incr_out` = 0.
- Transfer rules:
  - accept = `valid_in` & `ready_out`.
  - consume = `valid_out` & !`wb_stall_in`.
- Capture-time sanitising: `reg_we` stored as `reg_we_in` & (`reg_waddr_in`!=0).
- Output gating:
  - `reg_we_out`, `csr_we_out` = stored enable & `valid_out`.
  - `instret_incr_out` = consume (combinational from state and `wb_stall_in`).
  - A stalled entry holds all outputs stable and writes each cycle it is presented; regfile/csrfile writes are idempotent.
- Latency: 1 cycle from accept to `valid_out` when the buffer is empty.
- States (SKID_EN=1), with occupancy count:
  - EMPTY: accept -> ONE (out<=in).
  - ONE:
    - accept & consume -> ONE (out<=in).
    - accept & !consume -> TWO (skid<=in).
    - !accept & consume -> EMPTY.
    - else hold.
  - TWO: `ready_out`=0; consume -> ONE (out<=skid); else hold.
  - `ready_out` = !skid_valid (registered, no combinational path from `wb_stall_in`).
- SKID_EN=0:
  - single entry; `ready_out` = !`valid_out` | !`wb_stall_in` (combinational).
  - accept loads out; consume without accept empties it.
- Flush, highest priority after reset:
  - next state EMPTY; payload regs zeroed.
  - the same-cycle `valid_in` is not accepted, even if `ready_out`=1.
  - The output entry present in the flush cycle still commits that cycle if not stalled (`instret_incr_out`=1). If stalled it is discarded with no retire.
- Simultaneous flush & reset: reset wins.
- Reset mid-stall: entries are lost; no pulse is emitted.
- `instret_incr_out` never asserts on a cycle with `valid_out`=0.
- No wrap-around exists; occupancy is saturating at 0..2 by construction (assertion: never 3).

Decomposition:
- `defines.v` holds:
  - DATA_W/RADDR_W/CSR_ADDR_W defaults.
  - ZERO, ZERO_REG, CSR_ZERO_ADDR.
  - WRITE_ENABLE/WRITE_DISABLE.
  - the packed payload field order {csr_waddr, csr_wdata, csr_we, reg_waddr, reg_wdata, reg_we}.
- Sub-module `mem_wb_slot`: one payload register with load/clear/async reset, width = packed payload. Instantiated twice (out, skid), or once when SKID_EN=0.

Test Plan:
- Reset:
  - Stimulus: `reset_n_in`=0 mid-cycle, random inputs.
  - Response: outputs zero immediately (async), `ready_out`=1, no `instret_incr_out` for 2 cycles after release.
- Stream:
  - Stimulus: `valid_in`=1 every cycle, `wb_stall_in`=0, waddr=1..8, wdata=0x100+n.
  - Response: each appears on `reg_*_out` 1 cycle later, `instret_incr_out`=1 per cycle, 8 retires total.
- Stall and skid:
  - Stimulus: `wb_stall_in`=1 for 3 cycles while sending A, B, C.
  - Response: A held at output; B in skid; `ready_out`=0 from the cycle after B; C held upstream.
  - After release: A, B, C retire on consecutive cycles; none lost or duplicated.
- x0 write:
  - Stimulus: `reg_we_in`=1, `reg_waddr_in`=0, data 0xDEADBEEF.
  - Response: `reg_we_out`=0, `valid_out`=1, `instret_incr_out`=1.
- Flush:
  - Stimulus: TWO state with `wb_stall_in`=1, then `interrupt_flush_in`=1 with `valid_in`=1 (D).
  - Response: next cycle `valid_out`=0; D not accepted; zero retires for A/B; all enables 0.
- SKID_EN=0 build:
  - Stimulus: repeat the stall scenario.
  - Response: `ready_out` falls in the same cycle as `wb_stall_in` with `valid_out`=1; ordering preserved.
